// File: rtl/data_sender.sv
// data_sender: serialises one wide word into a stream of bytes for a byte-wide
// transmitter (e.g. a UART TX). A start request captures dataIn; each done
// pulse from the transmitter advances to the next byte. New data is refused
// until the final byte of the current word is being presented.
//
// Ports:
//   clk                rising-edge clock
//   rst                synchronous reset, active-low (0 = reset)
//   dataIn             word to transmit, sampled only when a start is accepted
//   transmissionStart  request to capture dataIn and begin sending
//   transmissionDone   1-cycle pulse from the transmitter: current byte sent
//   dataOut            byte presented to the transmitter (registered)
//   busy               word in flight and not yet on its last byte (registered)
//   lastByte           dataOut holds the final byte of the word (registered)
//
// Configuration macro:
//   DATA_SENDER_MSB_FIRST_EN  defined: most-significant byte first;
//                             undefined (default): least-significant byte first.
module data_sender #(
    parameter int unsigned BYTES      = 5,
    parameter int unsigned BYTE_WIDTH = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [BYTES*BYTE_WIDTH-1:0] dataIn,
    input  logic                        transmissionStart,
    input  logic                        transmissionDone,
    output logic [BYTE_WIDTH-1:0]       dataOut,
    output logic                        busy,
    output logic                        lastByte
);

    localparam int unsigned IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t                        state;
    logic [BYTES*BYTE_WIDTH-1:0]   holding;
    logic [IDX_W-1:0]              index;
    logic [IDX_W-1:0]              sel;
    logic [BYTE_WIDTH-1:0]         cur_byte;
    logic                          at_last;

    assign at_last = (index == LAST_IDX);

    // Byte selected from the holding register for the current index.
    always_comb begin
`ifdef DATA_SENDER_MSB_FIRST_EN
        sel = LAST_IDX - index;
`else
        sel = index;
`endif
        cur_byte = '0;
        for (int unsigned i = 0; i < BYTES; i++) begin
            if (sel == IDX_W'(i)) begin
                cur_byte = holding[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
    end

    // Outputs are a registered view of the state/index/holding of the
    // previous cycle, so dataOut, busy and lastByte always change together.
    // In IDLE, index only equals LAST_IDX after a completed word (reset and
    // start both clear it), which is exactly when lastByte must stay high.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            holding  <= '0;
            index    <= '0;
            dataOut  <= '0;
            busy     <= 1'b0;
            lastByte <= 1'b0;
        end else begin
            dataOut  <= cur_byte;
            busy     <= (state == SEND) && !at_last;
            lastByte <= at_last;

            case (state)
                IDLE: begin
                    if (transmissionStart) begin
                        holding <= dataIn;
                        index   <= '0;
                        state   <= SEND;
                    end
                end
                SEND: begin
                    // On the last byte a start beats a simultaneous done.
                    if (at_last && transmissionStart) begin
                        holding <= dataIn;
                        index   <= '0;
                    end else if (transmissionDone) begin
                        if (at_last) begin
                            state <= IDLE;
                        end else begin
                            index <= index + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_sender.sv
// Self-checking bench for data_sender (default LSB-first build). Each table
// row is applied for one clock; outputs are sampled on the following falling
// edge and reflect the state produced by the previous rows.
module tb_data_sender;

    localparam int unsigned BYTES      = 5;
    localparam int unsigned BYTE_WIDTH = 8;

    localparam logic [39:0] D1 = 40'h11_2233_4455;
    localparam logic [39:0] D2 = 40'h12_3456_789A;

    logic                        clk;
    logic                        rst;
    logic [BYTES*BYTE_WIDTH-1:0] dataIn;
    logic                        transmissionStart;
    logic                        transmissionDone;
    logic [BYTE_WIDTH-1:0]       dataOut;
    logic                        busy;
    logic                        lastByte;

    int checks;
    int failures;

    data_sender #(
        .BYTES      (BYTES),
        .BYTE_WIDTH (BYTE_WIDTH)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .dataIn            (dataIn),
        .transmissionStart (transmissionStart),
        .transmissionDone  (transmissionDone),
        .dataOut           (dataOut),
        .busy              (busy),
        .lastByte          (lastByte)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        start;
        logic        done;
        logic [39:0] data;
        logic [7:0]  exp_data;
        logic        exp_busy;
        logic        exp_last;
    } vec_t;

    vec_t vecs[29];

    task automatic check_outputs(input string name, input logic [7:0] ed,
                                 input logic eb, input logic el);
        checks++;
        if (dataOut !== ed || busy !== eb || lastByte !== el) begin
            failures++;
            $display("FAIL %s: got dataOut=%02h busy=%0b lastByte=%0b, expected dataOut=%02h busy=%0b lastByte=%0b",
                     name, dataOut, busy, lastByte, ed, eb, el);
        end
    endtask

    task automatic step(input logic r, input logic s, input logic d, input logic [39:0] w);
        rst               = r;
        transmissionStart = s;
        transmissionDone  = d;
        dataIn            = w;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        checks   = 0;
        failures = 0;

        //          start done data  dataOut busy last
        vecs[0]  = '{1'b0, 1'b1, D1, 8'h00, 1'b0, 1'b0}; // done in IDLE ignored
        vecs[1]  = '{1'b0, 1'b0, D1, 8'h00, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, D1, 8'h00, 1'b0, 1'b0}; // start with D1
        vecs[3]  = '{1'b0, 1'b0, D2, 8'h55, 1'b1, 1'b0}; // dataIn change unseen
        vecs[4]  = '{1'b0, 1'b1, D2, 8'h55, 1'b1, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, D2, 8'h44, 1'b1, 1'b0}; // start while busy
        vecs[6]  = '{1'b0, 1'b0, D2, 8'h44, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, D2, 8'h44, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, D2, 8'h33, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, D2, 8'h33, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 1'b1, D2, 8'h22, 1'b1, 1'b0}; // back-to-back done
        vecs[11] = '{1'b0, 1'b0, D2, 8'h11, 1'b0, 1'b1};
        vecs[12] = '{1'b1, 1'b1, D2, 8'h11, 1'b0, 1'b1}; // start+done on last: restart
        vecs[13] = '{1'b0, 1'b0, D1, 8'h9A, 1'b1, 1'b0};
        vecs[14] = '{1'b0, 1'b1, D1, 8'h9A, 1'b1, 1'b0};
        vecs[15] = '{1'b0, 1'b1, D1, 8'h78, 1'b1, 1'b0};
        vecs[16] = '{1'b0, 1'b1, D1, 8'h56, 1'b1, 1'b0};
        vecs[17] = '{1'b0, 1'b1, D1, 8'h34, 1'b1, 1'b0};
        vecs[18] = '{1'b0, 1'b0, D1, 8'h12, 1'b0, 1'b1};
        vecs[19] = '{1'b0, 1'b1, D1, 8'h12, 1'b0, 1'b1}; // final done -> IDLE
        vecs[20] = '{1'b0, 1'b0, D1, 8'h12, 1'b0, 1'b1}; // IDLE holds last byte
        vecs[21] = '{1'b0, 1'b1, D1, 8'h12, 1'b0, 1'b1}; // extra done ignored
        vecs[22] = '{1'b0, 1'b0, D1, 8'h12, 1'b0, 1'b1};
        vecs[23] = '{1'b1, 1'b0, D1, 8'h12, 1'b0, 1'b1}; // start from IDLE
        vecs[24] = '{1'b0, 1'b0, D2, 8'h55, 1'b1, 1'b0};
        vecs[25] = '{1'b0, 1'b1, D2, 8'h55, 1'b1, 1'b0};
        vecs[26] = '{1'b0, 1'b0, D2, 8'h44, 1'b1, 1'b0};
        vecs[27] = '{1'b1, 1'b1, D2, 8'h44, 1'b1, 1'b0}; // start+done mid-word: done wins
        vecs[28] = '{1'b0, 1'b0, D2, 8'h33, 1'b1, 1'b0};

        rst               = 1'b0;
        transmissionStart = 1'b0;
        transmissionDone  = 1'b0;
        dataIn            = '0;
        @(negedge clk);

        // Reset, including a start request that reset must override.
        step(1'b0, 1'b0, 1'b0, D1);
        step(1'b0, 1'b1, 1'b0, D1);
        check_outputs("reset", 8'h00, 1'b0, 1'b0);

        for (int i = 0; i < 29; i++) begin
            step(1'b1, vecs[i].start, vecs[i].done, vecs[i].data);
            check_outputs($sformatf("vec%0d", i), vecs[i].exp_data,
                          vecs[i].exp_busy, vecs[i].exp_last);
        end

        // Reset mid-word (index 2 of D1) aborts; next start recaptures dataIn.
        step(1'b0, 1'b0, 1'b0, D1);
        check_outputs("midreset", 8'h00, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, D1);
        check_outputs("post_reset_done", 8'h00, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, D1);
        check_outputs("post_reset_idle", 8'h00, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, D2);
        check_outputs("restart_accept", 8'h00, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, D1);
        check_outputs("restart_byte0", 8'h9A, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1, D1);
        check_outputs("restart_done0", 8'h9A, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, D1);
        check_outputs("restart_byte1", 8'h78, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
